// File: rtl/thiele_pkg.sv
// rtl/thiele_pkg.sv - shared CRC-32 constants, FSM encoding and byte update function
// Purpose: constants and helpers shared by the state digest block.
// Contents: CRC_POLY/CRC_INIT/CRC_XOROUT, state_t, crc32_byte().
package thiele_pkg;

  localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Reflected CRC-32 update for one byte, LSB first; the loop unrolls into
  // eight shift/XOR stages.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with extra-bit full/empty pointers
// Purpose: buffers incoming bytes between acceptance and CRC folding.
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data
//        (pop_data is the current head, valid while !empty), full, empty.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Same index with differing wrap bits means the writer is a lap ahead.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/state_digest_crc32.sv
// rtl/state_digest_crc32.sv - CRC-32 digest and byte count of a serialized state frame
// Purpose: buffers frame bytes, folds one per cycle into a CRC-32, and holds
//          the finished digest until the consumer takes it.
// Ports: clk, rst_n (async active-low); in_byte/in_byte_valid/in_byte_ready
//        byte input; frame_end pulse; digest/byte_count/digest_valid/
//        digest_ready result handshake; overrun sticky flag.
module state_digest_crc32
  import thiele_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_byte_valid,
  output logic        in_byte_ready,
  input  logic        frame_end,
  output logic [31:0] digest,
  output logic [31:0] byte_count,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic        overrun
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] crc;
  logic [31:0] count;
  logic        push;
  logic        pop;
  logic [7:0]  pop_data;
  logic        full;
  logic        empty;

  // rst_n gates ready so nothing is offered as accepted while reset is held.
  assign in_byte_ready = rst_n && !full && (state != ST_DRAIN) && (state != ST_HOLD);
  assign push          = in_byte_valid && in_byte_ready;
  assign pop           = !empty && ((state == ST_ACCUM) || (state == ST_DRAIN));
  assign digest_valid  = (state == ST_HOLD);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(in_byte),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // frame_end wins over a same-cycle byte in IDLE; that byte is already in the
  // FIFO and DRAIN folds it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_end) begin
          state_nxt = ST_DRAIN;
        end else if (push) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (frame_end) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (digest_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc        <= CRC_INIT;
      count      <= '0;
      digest     <= '0;
      byte_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if ((state == ST_HOLD) && digest_ready) begin
        crc   <= CRC_INIT;
        count <= '0;
      end else if (pop) begin
        crc   <= crc32_byte(crc, pop_data);
        count <= count + 32'd1;
      end
      // DRAIN sees empty only after the last fold has landed in crc.
      if ((state == ST_DRAIN) && empty) begin
        digest     <= crc ^ CRC_XOROUT;
        byte_count <= count;
      end
      if ((state == ST_HOLD) && frame_end) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/state_digest_crc32.md
STATE_DIGEST_CRC32 -- requirements
Module: state_digest_crc32

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input byte buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_byte  input  8  serialized state byte from the upstream serializer.
REQ-005 SHALL have port in_byte_valid  input  1  in_byte is valid.
REQ-006 SHALL have port in_byte_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port frame_end  input  1  one-cycle pulse: the upstream serialization is complete.
REQ-008 SHALL have port digest  output  32  CRC-32 of the frame.
REQ-009 SHALL have port byte_count  output  32  bytes in the frame.
REQ-010 SHALL have port digest_valid  output  1  digest and byte_count are valid.
REQ-011 SHALL have port digest_ready  input  1  consumer takes the digest.
REQ-012 SHALL have port overrun  output  1  sticky flag: frame_end was received while in HOLD.

Function
REQ-013 SHALL compute CRC-32/IEEE: reflected, poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, final XOR 0xFFFFFFFF.
REQ-014 SHALL accept a byte on a cycle where in_byte_valid && in_byte_ready; accepted bytes are written to the FIFO.
REQ-015 SHALL drive in_byte_ready = FIFO not full && state != HOLD && state != DRAIN.
REQ-016 SHALL pop at most one FIFO entry per cycle and fold it into the CRC register in that cycle; byte_count increments by 1 per fold, modulo 2^32.
REQ-017 SHALL make a byte accepted in cycle N folded no earlier than N+1; with an empty FIFO and no stall, it SHALL be folded in N+1.
REQ-018 SHALL implement states IDLE, ACCUM, DRAIN, HOLD.
REQ-019 IDLE: crc=0xFFFFFFFF, count=0; a byte acceptance moves the block to ACCUM; frame_end moves it to DRAIN.
REQ-020 ACCUM: frame_end moves the block to DRAIN; a byte accepted in the same cycle as frame_end belongs to the frame.
REQ-021 DRAIN: folds the remaining FIFO entries; when the FIFO is empty, the block latches digest=crc^0xFFFFFFFF and byte_count, then goes to HOLD.
REQ-022 HOLD: digest_valid=1; digest and byte_count are stable until digest_valid && digest_ready; that handshake moves the block to IDLE and reinitialises crc and count in the same edge.
REQ-023 An empty frame (frame_end in IDLE) SHALL yield digest 0x00000000, byte_count 0.
REQ-024 frame_end in HOLD SHALL be ignored for the digest and SHALL set overrun; overrun clears only on reset.
REQ-025 frame_end in DRAIN SHALL be ignored.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-027 Simultaneous push and pop on a full FIFO SHALL NOT occur, because in_ready=0 when the FIFO is full; simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged.

Reset
REQ-028 On rst_n low: state=IDLE, crc=0xFFFFFFFF, count=0, FIFO empty, digest=0, byte_count=0, digest_valid=0, overrun=0, in_byte_ready=0 while asserted.
REQ-029 Reset mid-frame SHALL discard all buffered bytes and the partial CRC; the first frame after reset is computed from scratch.

Structure
REQ-030 CRC polynomial, init and final-XOR constants and the state encoding SHALL live in the shared package thiele_pkg.
REQ-031 The byte buffer SHALL be a sub-module, byte_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty).
REQ-032 The per-byte CRC update SHALL be a combinational function (8 unrolled shift/XOR steps) in thiele_pkg.

Verification
REQ-033 ASCII "123456789" streamed at full rate, then frame_end -> digest 0xCBF43926, byte_count 9.
REQ-034 frame_end with no bytes -> digest 0x00000000, byte_count 0, digest_valid one cycle after DRAIN.
REQ-035 Single byte 0x00 with frame_end in the same cycle -> digest 0xD202EF8D, byte_count 1.
REQ-036 "123456789" with digest_ready held low for 10 cycles and random in_byte_valid gaps -> digest stays 0xCBF43926 while held, then IDLE the cycle after the handshake; the next frame "a" -> 0xE8B7BE43.
REQ-037 rst_n pulsed after 5 bytes with a full FIFO, then "123456789" -> 0xCBF43926, byte_count 9.
REQ-038 frame_end pulsed in HOLD -> overrun=1, digest unchanged, stays 1 across later frames until reset.
